// File: rtl/nibble_serial_adder_ctrl.sv
// Sequencer that drives an external 4-bit ripple-carry adder one nibble per cycle,
// LSB nibble first, and assembles the wide sum plus final carry behind valid/ready.
module nibble_serial_adder_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NIBBLES-1:0] in_a,
   input  logic [4*NIBBLES-1:0] in_b,
   input  logic                 in_cin,
   output logic [3:0]           add_a,
   output logic [3:0]           add_b,
   output logic                 add_c0,
   input  logic [3:0]           add_sum,
   input  logic                 add_c4,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] out_sum,
   output logic                 out_cout
);

   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic             carry_reg;
   logic [W-1:0]     op_a;
   logic [W-1:0]     op_b;
   logic [W-1:0]     res;
   logic [W-1:0]     sh_a;
   logic [W-1:0]     sh_b;

   // Shifting by 4*idx selects the current nibble without a variable part-select.
   assign sh_a = op_a >> {idx, 2'b00};
   assign sh_b = op_b >> {idx, 2'b00};

   assign add_a  = (state == RUN) ? sh_a[3:0] : 4'h0;
   assign add_b  = (state == RUN) ? sh_b[3:0] : 4'h0;
   assign add_c0 = (state == RUN) ? carry_reg : 1'b0;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign out_sum   = res;
   assign out_cout  = carry_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         carry_reg <= 1'b0;
         op_a      <= '0;
         op_b      <= '0;
         res       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_a      <= in_a;
                  op_b      <= in_b;
                  carry_reg <= in_cin;
                  idx       <= '0;
                  state     <= RUN;
               end
            end
            RUN: begin
               for (int i = 0; i < NIBBLES; i++) begin
                  if (idx == IDX_W'(i)) res[4*i +: 4] <= add_sum;
               end
               carry_reg <= add_c4;
               if (idx == LAST_IDX) state <= DONE;
               else                 idx   <= idx + IDX_W'(1);
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: behavioural 4-bit adders close the loop for a
// NIBBLES=4 and a NIBBLES=1 instance; wide results are scoreboarded against a + b + cin.
module tb_nibble_serial_adder_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // NIBBLES=4 instance
   logic        in_valid4, in_ready4, in_cin4, out_valid4, out_ready4, out_cout4;
   logic [15:0] in_a4, in_b4, out_sum4;
   logic [3:0]  add_a4, add_b4, add_sum4;
   logic        add_c04, add_c44;

   // NIBBLES=1 instance
   logic        in_valid1, in_ready1, in_cin1, out_valid1, out_ready1, out_cout1;
   logic [3:0]  in_a1, in_b1, out_sum1;
   logic [3:0]  add_a1, add_b1, add_sum1;
   logic        add_c01, add_c41;

   assign {add_c44, add_sum4} = {1'b0, add_a4} + {1'b0, add_b4} + {4'b0, add_c04};
   assign {add_c41, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + {4'b0, add_c01};

   nibble_serial_adder_ctrl #(.NIBBLES(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid4), .in_ready(in_ready4),
      .in_a(in_a4), .in_b(in_b4), .in_cin(in_cin4),
      .add_a(add_a4), .add_b(add_b4), .add_c0(add_c04),
      .add_sum(add_sum4), .add_c4(add_c44),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .out_sum(out_sum4), .out_cout(out_cout4)
   );

   nibble_serial_adder_ctrl #(.NIBBLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1),
      .add_a(add_a1), .add_b(add_b1), .add_c0(add_c01),
      .add_sum(add_sum1), .add_c4(add_c41),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .out_sum(out_sum1), .out_cout(out_cout1)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [16:0] exp_q[$];
   logic [16:0] sb_exp;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_cmp++;
      if (got !== expv) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, expv, $time);
      end
   endtask

   // Scoreboard: each output handshake pops the oldest expected {cout, sum}.
   always @(negedge clk) begin
      if (rst_n && out_valid4 && out_ready4) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
         end else begin
            sb_exp = exp_q.pop_front();
            chk("sb_result", 32'({out_cout4, out_sum4}), 32'(sb_exp));
         end
      end
   end

   // Called just after a rising edge; returns just after the accept edge.
   task automatic send4(input logic [15:0] a, input logic [15:0] b, input logic c,
                        output int waited);
      waited    = 0;
      in_a4     = a;
      in_b4     = b;
      in_cin4   = c;
      in_valid4 = 1'b1;
      @(negedge clk);
      while (!in_ready4 && waited <= 40) begin
         waited++;
         @(negedge clk);
      end
      if (!in_ready4) chk("accept_timeout", 32'd1, 32'd0);
      exp_q.push_back({1'b0, a} + {1'b0, b} + {16'b0, c});
      @(posedge clk); #1;
      in_valid4 = 1'b0;
   endtask

   int w;

   initial begin
      rst_n = 1'b0;
      in_valid4 = 0; in_a4 = 0; in_b4 = 0; in_cin4 = 0; out_ready4 = 1;
      in_valid1 = 0; in_a1 = 0; in_b1 = 0; in_cin1 = 0; out_ready1 = 1;
      #3;
      chk("rst_in_ready",  32'(in_ready4),  32'd1);
      chk("rst_out_valid", 32'(out_valid4), 32'd0);
      chk("rst_out_sum",   32'(out_sum4),   32'd0);
      chk("rst_out_cout",  32'(out_cout4),  32'd0);
      chk("rst_add_bus",   32'({add_a4, add_b4, add_c04}), 32'd0);
      chk("rst_n1_ready",  32'(in_ready1),  32'd1);
      #20 rst_n = 1'b1;
      @(posedge clk); #1;

      // Plain add with exact output latency.
      send4(16'h1234, 16'h1111, 1'b0, w);
      repeat (4) begin
         @(negedge clk);
         chk("lat_valid_low", 32'(out_valid4), 32'd0);
      end
      @(negedge clk);
      chk("lat_valid_high", 32'(out_valid4), 32'd1);
      chk("lat_sum", 32'(out_sum4), 32'h2345);
      @(posedge clk); #1;

      // Carry ripples through every nibble.
      send4(16'hFFFF, 16'h0001, 1'b0, w);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("ripple_c0", 32'(add_c04), (k == 0) ? 32'd0 : 32'd1);
      end
      repeat (2) @(posedge clk); #1;

      send4(16'hFFFF, 16'hFFFF, 1'b1, w);
      repeat (6) @(posedge clk); #1;

      // Backpressure: result must hold while out_ready is low.
      out_ready4 = 1'b0;
      send4(16'h1234, 16'h4321, 1'b1, w);
      w = 0;
      while (!out_valid4 && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("bp_valid", 32'(out_valid4), 32'd1);
      repeat (5) begin
         @(negedge clk);
         chk("bp_sum",   32'(out_sum4),  32'h5556);
         chk("bp_cout",  32'(out_cout4), 32'd0);
         chk("bp_ready", 32'(in_ready4), 32'd0);
      end
      @(posedge clk); #1;
      out_ready4 = 1'b1;
      @(posedge clk); #1;

      // A request raised during RUN waits for IDLE and does not disturb the active op.
      send4(16'h0101, 16'h0202, 1'b0, w);
      send4(16'hAAAA, 16'h0001, 1'b0, w);
      chk("busy_accept_wait", 32'(w), 32'd5);
      repeat (6) @(posedge clk); #1;

      // Asynchronous reset in the second RUN cycle discards the operation.
      send4(16'h1234, 16'h0101, 1'b0, w);
      @(posedge clk); #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("mid_rst_valid", 32'(out_valid4), 32'd0);
      chk("mid_rst_ready", 32'(in_ready4),  32'd1);
      chk("mid_rst_sum",   32'(out_sum4),   32'd0);
      chk("mid_rst_add_a", 32'(add_a4),     32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      send4(16'h0F0F, 16'h00F1, 1'b0, w);
      repeat (6) @(posedge clk); #1;

      // Single-nibble instance: RUN lasts one cycle.
      in_a1 = 4'h9; in_b1 = 4'h8; in_cin1 = 1'b1; in_valid1 = 1'b1;
      @(negedge clk);
      chk("n1_ready", 32'(in_ready1), 32'd1);
      @(posedge clk); #1;
      in_valid1 = 1'b0; in_a1 = 4'h0; in_b1 = 4'h0; in_cin1 = 1'b0;
      @(negedge clk);
      chk("n1_valid_low", 32'(out_valid1), 32'd0);
      @(negedge clk);
      chk("n1_valid_high", 32'(out_valid1), 32'd1);
      chk("n1_sum",  32'(out_sum1),  32'h2);
      chk("n1_cout", 32'(out_cout1), 32'd1);
      @(posedge clk); #1;

      // Random back-to-back traffic on the 4-nibble instance.
      for (int i = 0; i < 200; i++) begin
         send4(16'($urandom), 16'($urandom), 1'($urandom), w);
      end
      w = 0;
      while (exp_q.size() != 0 && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencing stage wrapped around the team's 4-bit ripple-carry adder (`4bits`), which it drives combinationally. It accepts two wide operands through a valid/ready handshake and feeds the adder one nibble per cycle, LSB nibble first. It registers the adder's carry-out back into the next nibble's carry-in and assembles the wide sum. The result is presented on a valid/ready output. This lets a single 4-bit adder instance serve arbitrary operand widths.

## Interface
- NIBBLES, default 4: operand width in nibbles; operand width W = 4*NIBBLES; legal range 1..16.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request carries a valid operand pair.
- in_ready  out  1  block can accept a request.
- in_a  in  W  operand A; bit 0 is the LSB.
- in_b  in  W  operand B; bit 0 is the LSB.
- in_cin  in  1  carry-in to nibble 0.
- add_a  out  4  to adder input `a`; bit 0 is the LSB.
- add_b  out  4  to adder input `b`.
- add_c0  out  1  to adder input `c0`.
- add_sum  in  4  from adder output `sum`; index 0 is the LSB.
- add_c4  in  1  from adder output `c4`.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  W  registered wide sum.
- out_cout  out  1  carry out of the most significant nibble.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE**
  - in_ready=1 and out_valid=0.
  - On in_valid=1 at a clock edge:
    - latch in_a/in_b into op registers;
    - carry_reg <= in_cin;
    - idx <= 0;
    - go to RUN.
- **RUN**
  - in_ready=0.
  - Drive add_a = op_a[4*idx+3:4*idx], add_b = op_b[4*idx+3:4*idx], add_c0 = carry_reg.
  - Each edge:
    - result nibble idx <= add_sum;
    - carry_reg <= add_c4.
  - If idx==NIBBLES-1, go to DONE; otherwise idx <= idx+1.
  - The adder path is purely combinational within the cycle; no adder latency is assumed.
- **DONE**
  - out_valid=1.
  - out_sum = result register; out_cout = carry_reg.
  - Both hold stable until handshake.
  - On out_valid & out_ready at an edge, go to IDLE.
- Outside RUN, add_a, add_b and add_c0 are driven to 0.
- The idx counter width is clog2(NIBBLES), minimum 1 bit. It never wraps beyond NIBBLES-1.
- Arithmetic: {out_cout, out_sum} == in_a + in_b + in_cin, exact at (W+1) bits. No saturation.
- in_a, in_b and in_cin are sampled only on the accept edge; later changes have no effect.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0;
  - out_sum=0, out_cout=0;
  - add_a=0, add_b=0, add_c0=0;
  - idx=0, carry_reg=0, op registers=0.
- Accept edge = edge E0. out_valid rises after edge E0+NIBBLES (latency NIBBLES cycles).
- Minimum spacing between accepts is NIBBLES+2 cycles:
  - NIBBLES cycles in RUN;
  - at least 1 cycle in DONE;
  - 1 cycle in IDLE.
- in_ready is combinational from state only. It never depends on in_valid.
- in_valid while not in IDLE: ignored, request not consumed; the upstream must hold it.
- out_ready=0 in DONE: stall indefinitely with outputs stable.
- out_ready high before out_valid: no effect.
- Reset mid-RUN or mid-DONE: operation discarded and no result is produced. After rst_n rises, the block is in IDLE and accepts on the first edge with in_valid=1.
- NIBBLES=1: RUN lasts exactly one cycle.

## Test plan
- NIBBLES=4, in_a=0x1234, in_b=0x1111, in_cin=0 -> out_sum=0x2345, out_cout=0; out_valid asserted after the 4th edge following accept.
- in_a=0xFFFF, in_b=0x0001, in_cin=0 -> out_sum=0x0000, out_cout=1. Carry must ripple through all four nibbles; check add_c0=1 in RUN cycles 1..3.
- in_a=0xFFFF, in_b=0xFFFF, in_cin=1 -> out_sum=0xFFFF, out_cout=1.
- Backpressure and operand stability:
  - hold out_ready=0 for 5 cycles in DONE -> out_sum/out_cout stable, in_ready=0;
  - drive new in_valid with in_a=0xAAAA during RUN -> no effect on the result, request accepted only after return to IDLE.
- Reset mid-operation: assert rst_n=0 during the 2nd RUN cycle -> immediately out_valid=0, in_ready=1, out_sum=0, add_a=0. The next op 0x0F0F+0x00F1, cin 0 -> 0x1000, cout 0.
- NIBBLES=1: in_a=0x9, in_b=0x8, in_cin=1 -> out_sum=0x2, out_cout=1, out_valid after 1 edge. Follow with 200 random back-to-back ops checked against a reference model for NIBBLES=4.
